// File: rtl/program_counter_unit.sv
// Program counter for the k6502 core: per-lane load/hold select followed by an
// increment whose carry either ripples at once or advances one lane per clock.
module program_counter_unit #(
  parameter int unsigned                 BYTES          = 2,
  parameter int unsigned                 BYTE_WIDTH     = 8,
  parameter int unsigned                 DEFERRED_CARRY = 0,
  parameter logic [BYTES*BYTE_WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic                                 ph0,
  input  logic                                 reset,
  input  logic [BYTES-1:0]                     load_en,
  input  logic [BYTES*BYTE_WIDTH-1:0]          bus_in,
  input  logic                                 inc,
  output logic [BYTES*BYTE_WIDTH-1:0]          pc_out,
  output logic [((BYTES > 1) ? BYTES-1 : 1)-1:0] carry_pending,
  output logic                                 wrap,
  output logic                                 busy
);

  localparam int unsigned PCW = BYTES * BYTE_WIDTH;
  localparam int unsigned PW  = (BYTES > 1) ? BYTES - 1 : 1;

  logic [PCW-1:0] pc_q;
  logic [PCW-1:0] sel;
  logic [PCW-1:0] pc_next;
  logic [PW-1:0]  pend_q;
  logic [PW-1:0]  pend_next;
  logic           wrap_q;
  logic           wrap_next;
  logic           busy_q;

  for (genvar k = 0; k < BYTES; k++) begin : g_sel
    assign sel[k*BYTE_WIDTH +: BYTE_WIDTH] =
      load_en[k] ? bus_in[k*BYTE_WIDTH +: BYTE_WIDTH] : pc_q[k*BYTE_WIDTH +: BYTE_WIDTH];
  end

  if (DEFERRED_CARRY != 0) begin : g_deferred
    logic [BYTES-1:0] lane_cin;
    logic [BYTES-1:0] lane_cout;

    // A load on the receiving lane swallows the waiting carry: the bus already
    // holds the corrected byte.
    assign lane_cin[0] = inc;
    for (genvar k = 1; k < BYTES; k++) begin : g_cin
      assign lane_cin[k] = pend_q[k-1] & ~load_en[k];
    end

    for (genvar k = 0; k < BYTES; k++) begin : g_lane
      logic [BYTE_WIDTH:0] sum;
      assign sum = {1'b0, sel[k*BYTE_WIDTH +: BYTE_WIDTH]} + {{BYTE_WIDTH{1'b0}}, lane_cin[k]};
      assign pc_next[k*BYTE_WIDTH +: BYTE_WIDTH] = sum[BYTE_WIDTH-1:0];
      assign lane_cout[k] = sum[BYTE_WIDTH];
    end

    if (BYTES > 1) begin : g_pend
      assign pend_next = lane_cout[BYTES-2:0];
    end else begin : g_nopend
      assign pend_next = '0;
    end
    assign wrap_next = lane_cout[BYTES-1];
  end else begin : g_immediate
    logic [PCW:0] sum;
    assign sum       = {1'b0, sel} + {{PCW{1'b0}}, inc};
    assign pc_next   = sum[PCW-1:0];
    assign wrap_next = sum[PCW];
    assign pend_next = '0;
  end

  always_ff @(posedge ph0 or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_VALUE;
      pend_q <= '0;
      wrap_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      pc_q   <= pc_next;
      pend_q <= pend_next;
      wrap_q <= wrap_next;
      busy_q <= |pend_next;
    end
  end

  assign pc_out        = pc_q;
  assign carry_pending = pend_q;
  assign wrap          = wrap_q;
  assign busy          = busy_q;

  a_ctrl_known: assert property (@(posedge ph0) disable iff (reset) !$isunknown({load_en, inc}));

endmodule

// File: tb/tb_program_counter_unit.sv
// Bench for program_counter_unit: immediate 2-lane, deferred 2-lane and deferred
// 3-lane instances driven by vector tables, corner sequences and random stimulus.
module tb_program_counter_unit;

  logic        ph0 = 1'b0;
  logic        reset;
  logic [1:0]  a_le, b_le;
  logic [2:0]  c_le;
  logic [15:0] a_bus, b_bus, a_pc, b_pc;
  logic [23:0] c_bus, c_pc;
  logic        a_inc, b_inc, c_inc;
  logic [0:0]  a_pend, b_pend;
  logic [1:0]  c_pend;
  logic        a_wrap, b_wrap, c_wrap, a_busy, b_busy, c_busy;

  int unsigned nerr = 0;
  int unsigned nchk = 0;

  typedef struct packed {
    logic [3:0][7:0] lane;
    logic [3:0]      pend;
    logic            wrap;
  } mstate_t;

  typedef struct packed {
    logic [1:0]  le;
    logic [15:0] bus;
    logic        inc;
    logic [15:0] pc;
    logic        wrap;
  } vec_t;

  vec_t    tbl [14];
  mstate_t ma, mb, mc;

  program_counter_unit #(.BYTES(2), .BYTE_WIDTH(8), .DEFERRED_CARRY(0), .RESET_VALUE(16'hFFFC)) u_a (
    .ph0(ph0), .reset(reset), .load_en(a_le), .bus_in(a_bus), .inc(a_inc),
    .pc_out(a_pc), .carry_pending(a_pend), .wrap(a_wrap), .busy(a_busy));

  program_counter_unit #(.BYTES(2), .BYTE_WIDTH(8), .DEFERRED_CARRY(1), .RESET_VALUE(16'h0000)) u_b (
    .ph0(ph0), .reset(reset), .load_en(b_le), .bus_in(b_bus), .inc(b_inc),
    .pc_out(b_pc), .carry_pending(b_pend), .wrap(b_wrap), .busy(b_busy));

  program_counter_unit #(.BYTES(3), .BYTE_WIDTH(8), .DEFERRED_CARRY(1), .RESET_VALUE(24'h000000)) u_c (
    .ph0(ph0), .reset(reset), .load_en(c_le), .bus_in(c_bus), .inc(c_inc),
    .pc_out(c_pc), .carry_pending(c_pend), .wrap(c_wrap), .busy(c_busy));

  always #5 ph0 = ~ph0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge ph0);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] lane_of(input logic [31:0] w, input int k);
    return 8'(w >> (8 * k));
  endfunction

  // Reference: whole-value add in immediate mode, per-byte add with a one-clock
  // carry hand-off in deferred mode.
  function automatic mstate_t mstep(input mstate_t s, input int nb, input bit def,
                                    input logic [3:0] le, input logic [31:0] bus, input logic inc);
    mstate_t         n = '0;
    longint unsigned tot = 0;
    int unsigned     base, cin, v;
    if (!def) begin
      for (int k = nb - 1; k >= 0; k--)
        tot = (tot << 8) + longint'(le[k] ? lane_of(bus, k) : s.lane[k]);
      tot = tot + longint'(inc);
      n.wrap = (tot >> (8 * nb)) != 0;
      for (int k = 0; k < nb; k++) n.lane[k] = 8'(tot >> (8 * k));
    end else begin
      for (int k = 0; k < nb; k++) begin
        base = le[k] ? int'(lane_of(bus, k)) : int'(s.lane[k]);
        if (k == 0) cin = int'(inc);
        else        cin = le[k] ? 0 : int'(s.pend[k-1]);
        v = base + cin;
        n.lane[k] = 8'(v);
        if (k < nb - 1) n.pend[k] = (v > 255);
        else            n.wrap    = (v > 255);
      end
    end
    return n;
  endfunction

  task automatic chk_m(input string nm, input logic [31:0] pc, input logic [3:0] pend,
                       input logic wr, input logic bz, input mstate_t m);
    chk({nm, ".pc"},   pc, 32'(m.lane));
    chk({nm, ".pend"}, 32'(pend), 32'(m.pend));
    chk({nm, ".wrap"}, 32'(wr), 32'(m.wrap));
    chk({nm, ".busy"}, 32'(bz), 32'(|m.pend));
  endtask

  task automatic b_step(input string nm, input logic [1:0] le, input logic [15:0] bus, input logic i,
                        input logic [15:0] pc, input logic pend, input logic wr);
    b_le = le; b_bus = bus; b_inc = i;
    tick();
    chk({nm, ".pc"},   32'(b_pc), 32'(pc));
    chk({nm, ".pend"}, 32'(b_pend), 32'(pend));
    chk({nm, ".wrap"}, 32'(b_wrap), 32'(wr));
    chk({nm, ".busy"}, 32'(b_busy), 32'(pend));
    b_le = '0; b_bus = '0; b_inc = 1'b0;
  endtask

  task automatic c_step(input string nm, input logic [2:0] le, input logic [23:0] bus, input logic i,
                        input logic [23:0] pc, input logic [1:0] pend, input logic wr);
    c_le = le; c_bus = bus; c_inc = i;
    tick();
    chk({nm, ".pc"},   32'(c_pc), 32'(pc));
    chk({nm, ".pend"}, 32'(c_pend), 32'(pend));
    chk({nm, ".wrap"}, 32'(c_wrap), 32'(wr));
    chk({nm, ".busy"}, 32'(c_busy), 32'(|pend));
    c_le = '0; c_bus = '0; c_inc = 1'b0;
  endtask

  function automatic logic [3:0] rand_le();
    return ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
  endfunction

  function automatic logic [31:0] rand_bus();
    logic [31:0] w = '0;
    for (int k = 0; k < 4; k++)
      w = w | (32'(($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom)) << (8 * k));
    return w;
  endfunction

  initial begin
    logic [15:0] seq_exp [3];
    logic [3:0]  le_r;
    logic [31:0] bus_r;
    logic        inc_r;

    reset = 1'b1;
    a_le = '0; a_bus = '0; a_inc = 1'b0;
    b_le = '0; b_bus = '0; b_inc = 1'b0;
    c_le = '0; c_bus = '0; c_inc = 1'b0;

    tbl[0]  = '{2'b00, 16'h0000, 1'b1, 16'hFFFD, 1'b0};
    tbl[1]  = '{2'b00, 16'h0000, 1'b1, 16'hFFFE, 1'b0};
    tbl[2]  = '{2'b00, 16'h0000, 1'b1, 16'hFFFF, 1'b0};
    tbl[3]  = '{2'b00, 16'h0000, 1'b1, 16'h0000, 1'b1};
    tbl[4]  = '{2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[5]  = '{2'b11, 16'h12FF, 1'b0, 16'h12FF, 1'b0};
    tbl[6]  = '{2'b00, 16'h0000, 1'b1, 16'h1300, 1'b0};
    tbl[7]  = '{2'b11, 16'h1234, 1'b0, 16'h1234, 1'b0};
    tbl[8]  = '{2'b01, 16'h557F, 1'b1, 16'h1280, 1'b0};
    tbl[9]  = '{2'b11, 16'hABCD, 1'b0, 16'hABCD, 1'b0};
    tbl[10] = '{2'b10, 16'hFF00, 1'b1, 16'hFFCE, 1'b0};
    tbl[11] = '{2'b00, 16'h0000, 1'b0, 16'hFFCE, 1'b0};
    tbl[12] = '{2'b11, 16'hFFFF, 1'b1, 16'h0000, 1'b1};
    tbl[13] = '{2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0};

    #2;
    chk("rst_a.pc",   32'(a_pc), 32'h0000FFFC);
    chk("rst_a.pend", 32'(a_pend), 32'h0);
    chk("rst_a.wrap", 32'(a_wrap), 32'h0);
    chk("rst_b.pc",   32'(b_pc), 32'h0);
    chk("rst_b.busy", 32'(b_busy), 32'h0);
    chk("rst_c.pc",   32'(c_pc), 32'h0);
    chk("rst_c.pend", 32'(c_pend), 32'h0);
    #10;
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      a_le = tbl[i].le; a_bus = tbl[i].bus; a_inc = tbl[i].inc;
      tick();
      chk($sformatf("vec%0d.pc", i),   32'(a_pc), 32'(tbl[i].pc));
      chk($sformatf("vec%0d.wrap", i), 32'(a_wrap), 32'(tbl[i].wrap));
      chk($sformatf("vec%0d.busy", i), 32'(a_busy), 32'h0);
      chk($sformatf("vec%0d.pend", i), 32'(a_pend), 32'h0);
    end
    a_le = '0; a_bus = '0; a_inc = 1'b0;

    b_step("def_load",     2'b11, 16'h12FF, 1'b0, 16'h12FF, 1'b0, 1'b0);
    b_step("def_inc",      2'b00, 16'h0000, 1'b1, 16'h1200, 1'b1, 1'b0);
    b_step("def_settle",   2'b00, 16'h0000, 1'b0, 16'h1300, 1'b0, 1'b0);
    b_step("ovr_load",     2'b11, 16'h12FF, 1'b0, 16'h12FF, 1'b0, 1'b0);
    b_step("ovr_inc",      2'b00, 16'h0000, 1'b1, 16'h1200, 1'b1, 1'b0);
    b_step("ovr_hi",       2'b10, 16'h4000, 1'b0, 16'h4000, 1'b0, 1'b0);
    b_step("ovr_hold",     2'b00, 16'h0000, 1'b0, 16'h4000, 1'b0, 1'b0);
    b_step("dbl_load",     2'b11, 16'h12FF, 1'b0, 16'h12FF, 1'b0, 1'b0);
    b_step("dbl_inc1",     2'b00, 16'h0000, 1'b1, 16'h1200, 1'b1, 1'b0);
    b_step("dbl_inc2",     2'b00, 16'h0000, 1'b1, 16'h1301, 1'b0, 1'b0);
    b_step("bwrap_load",   2'b11, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    b_step("bwrap_inc",    2'b00, 16'h0000, 1'b1, 16'hFF00, 1'b1, 1'b0);
    b_step("bwrap_top",    2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
    b_step("bwrap_clear",  2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

    c_step("rip_load",  3'b111, 24'h00FFFF, 1'b0, 24'h00FFFF, 2'b00, 1'b0);
    c_step("rip_inc",   3'b000, 24'h000000, 1'b1, 24'h00FF00, 2'b01, 1'b0);
    c_step("rip_1",     3'b000, 24'h000000, 1'b0, 24'h000000, 2'b10, 1'b0);
    c_step("rip_2",     3'b000, 24'h000000, 1'b0, 24'h010000, 2'b00, 1'b0);
    c_step("cw_load",   3'b111, 24'hFFFFFF, 1'b0, 24'hFFFFFF, 2'b00, 1'b0);
    c_step("cw_inc",    3'b000, 24'h000000, 1'b1, 24'hFFFF00, 2'b01, 1'b0);
    c_step("cw_1",      3'b000, 24'h000000, 1'b0, 24'hFF0000, 2'b10, 1'b0);
    c_step("cw_2",      3'b000, 24'h000000, 1'b0, 24'h000000, 2'b00, 1'b1);
    c_step("cw_3",      3'b000, 24'h000000, 1'b0, 24'h000000, 2'b00, 1'b0);

    b_step("mr_load", 2'b11, 16'h12FF, 1'b0, 16'h12FF, 1'b0, 1'b0);
    b_step("mr_inc",  2'b00, 16'h0000, 1'b1, 16'h1200, 1'b1, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    chk("mr_a.pc",   32'(a_pc), 32'h0000FFFC);
    chk("mr_b.pc",   32'(b_pc), 32'h0);
    chk("mr_b.pend", 32'(b_pend), 32'h0);
    chk("mr_b.busy", 32'(b_busy), 32'h0);
    chk("mr_c.pc",   32'(c_pc), 32'h0);
    #1;
    reset = 1'b0;
    seq_exp[0] = 16'hFFFD; seq_exp[1] = 16'hFFFE; seq_exp[2] = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      a_inc = 1'b1;
      tick();
      chk($sformatf("mr_seq%0d.a_pc", i), 32'(a_pc), 32'(seq_exp[i]));
      chk($sformatf("mr_seq%0d.b_pc", i), 32'(b_pc), 32'h0);
      chk($sformatf("mr_seq%0d.b_pend", i), 32'(b_pend), 32'h0);
    end
    a_inc = 1'b0;

    tick();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    ma = '0; ma.lane = 32'h0000FFFC;
    mb = '0;
    mc = '0;
    for (int i = 0; i < 400; i++) begin
      le_r = rand_le(); bus_r = rand_bus(); inc_r = 1'($urandom_range(0, 1));
      a_le = le_r[1:0]; a_bus = bus_r[15:0]; a_inc = inc_r;
      ma = mstep(ma, 2, 1'b0, le_r, bus_r, inc_r);
      le_r = rand_le(); bus_r = rand_bus(); inc_r = 1'($urandom_range(0, 1));
      b_le = le_r[1:0]; b_bus = bus_r[15:0]; b_inc = inc_r;
      mb = mstep(mb, 2, 1'b1, {2'b00, le_r[1:0]}, {16'h0, bus_r[15:0]}, inc_r);
      le_r = rand_le(); bus_r = rand_bus(); inc_r = 1'($urandom_range(0, 1));
      c_le = le_r[2:0]; c_bus = bus_r[23:0]; c_inc = inc_r;
      mc = mstep(mc, 3, 1'b1, {1'b0, le_r[2:0]}, {8'h0, bus_r[23:0]}, inc_r);
      tick();
      chk_m($sformatf("rnd%0d_a", i), 32'(a_pc), 4'(a_pend), a_wrap, a_busy, ma);
      chk_m($sformatf("rnd%0d_b", i), 32'(b_pc), 4'(b_pend), b_wrap, b_busy, mb);
      chk_m($sformatf("rnd%0d_c", i), 32'(c_pc), 4'(c_pend), c_wrap, c_busy, mc);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
